// File: rtl/usrdemux_pkg.sv
// usrdemux_pkg: shared types and constants for the packet demultiplexer.
//   state_t  - lock state of the dispatch FSM (IDLE, LOCK1, LOCK2)
//   SEL_O1   - usrdemux_sel value that steers a packet to output 1
//   SEL_O2   - usrdemux_sel value that steers a packet to output 2
package usrdemux_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK1 = 2'd1,
    LOCK2 = 2'd2
  } state_t;

  localparam logic SEL_O1 = 1'b0;
  localparam logic SEL_O2 = 1'b1;

endpackage

// File: rtl/usrdemux_pkt_if.sv
// usrdemux_pkt_if: one valid/ready beat stream with a packet-end flag.
//   valid - beat valid (source to sink)
//   ready - sink can take the beat (sink to source)
//   data  - WIDTH-bit beat payload
//   last  - final beat of the packet
// master = stream source, slave = stream sink.
interface usrdemux_pkt_if #(
  parameter int WIDTH = 64
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;
  logic             last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/usrdemux_oreg.sv
// usrdemux_oreg: one-entry registered output stage with a delivered-packet
// counter.
//   clk, rst   - clock, synchronous active-high reset
//   load       - a beat is accepted for this output on this edge
//   load_data  - beat payload to capture
//   load_last  - packet-end flag to capture
//   m          - registered output stream (master side)
//   can_load   - register is empty or draining this cycle
//   pkt_cnt    - packets whose last beat has left this output (wraps)
module usrdemux_oreg
  import usrdemux_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [WIDTH-1:0]     load_data,
  input  logic                 load_last,
  usrdemux_pkt_if.master       m,
  output logic                 can_load,
  output logic [CNT_W-1:0]     pkt_cnt
);

  logic             valid_r;
  logic [WIDTH-1:0] data_r;
  logic             last_r;
  logic [CNT_W-1:0] cnt_r;
  logic             handshake_s;

  assign handshake_s = valid_r & m.ready;
  assign can_load    = ~valid_r | m.ready;

  // Output register and counter; a new load takes priority over draining,
  // and the counter looks at the beat that is leaving, not the one arriving.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      data_r  <= '0;
      last_r  <= 1'b0;
      cnt_r   <= '0;
    end else begin
      if (load) begin
        valid_r <= 1'b1;
        data_r  <= load_data;
        last_r  <= load_last;
      end else if (handshake_s) begin
        valid_r <= 1'b0;
      end
      if (handshake_s && last_r) begin
        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign m.valid = valid_r;
  assign m.data  = data_r;
  assign m.last  = last_r;
  assign pkt_cnt = cnt_r;

endmodule

// File: rtl/usrdemux_pkt.sv
// usrdemux_pkt: packet-aware 1-to-2 stream demultiplexer.
//   clk, rst      - clock, synchronous active-high reset
//   usrdemux_sel  - route request, sampled on a packet's first beat only
//   s             - input stream (slave side)
//   o1, o2        - registered output streams (master side), 1-cycle latency
//   pkt_cnt1/2    - packets fully delivered on each output (wrap)
//   busy          - packet in progress or either output holds a beat
module usrdemux_pkt
  import usrdemux_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             usrdemux_sel,
  usrdemux_pkt_if.slave    s,
  usrdemux_pkt_if.master   o1,
  usrdemux_pkt_if.master   o2,
  output logic [CNT_W-1:0] pkt_cnt1,
  output logic [CNT_W-1:0] pkt_cnt2,
  output logic             busy
);

  state_t state_r;
  state_t state_nxt_s;
  logic   tgt_s;
  logic   can1_s;
  logic   can2_s;
  logic   s_ready_s;
  logic   accept_s;
  logic   load1_s;
  logic   load2_s;

  // Lock state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Target decode, input ready and next state. Ready is derived from the
  // target alone so it never waits on s.valid.
  always_comb begin
    tgt_s       = SEL_O1;
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    tgt_s = usrdemux_sel;
      LOCK1:   tgt_s = SEL_O1;
      LOCK2:   tgt_s = SEL_O2;
      default: tgt_s = SEL_O1;
    endcase
    s_ready_s = (tgt_s == SEL_O2) ? can2_s : can1_s;
    accept_s  = s.valid & s_ready_s;
    if (accept_s) begin
      if (s.last) begin
        state_nxt_s = IDLE;
      end else begin
        state_nxt_s = (tgt_s == SEL_O2) ? LOCK2 : LOCK1;
      end
    end else begin
      state_nxt_s = state_r;
    end
  end

  assign load1_s = accept_s & (tgt_s == SEL_O1);
  assign load2_s = accept_s & (tgt_s == SEL_O2);
  assign s.ready = s_ready_s;

  usrdemux_oreg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_oreg1 (
    .clk       (clk),
    .rst       (rst),
    .load      (load1_s),
    .load_data (s.data),
    .load_last (s.last),
    .m         (o1),
    .can_load  (can1_s),
    .pkt_cnt   (pkt_cnt1)
  );

  usrdemux_oreg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_oreg2 (
    .clk       (clk),
    .rst       (rst),
    .load      (load2_s),
    .load_data (s.data),
    .load_last (s.last),
    .m         (o2),
    .can_load  (can2_s),
    .pkt_cnt   (pkt_cnt2)
  );

  assign busy = (state_r != IDLE) | o1.valid | o2.valid;

endmodule

// File: tb/tb_usrdemux_pkt.sv
// Randomized bench for usrdemux_pkt. Two instances share the same stimulus:
// one with 16-bit counters and one with 2-bit counters to exercise wrap.
// The reference model keeps, per output, a queue of beats owed to it and a
// count of packets it has delivered.
module tb_usrdemux_pkt;
  localparam int W  = 64;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;
  always #5 clk = ~clk;

  usrdemux_pkt_if #(.WIDTH(W)) s_if ();
  usrdemux_pkt_if #(.WIDTH(W)) o1_if ();
  usrdemux_pkt_if #(.WIDTH(W)) o2_if ();
  usrdemux_pkt_if #(.WIDTH(W)) sb_if ();
  usrdemux_pkt_if #(.WIDTH(W)) o1b_if ();
  usrdemux_pkt_if #(.WIDTH(W)) o2b_if ();

  logic [CW-1:0] cnt1, cnt2;
  logic [1:0]    cntb1, cntb2;
  logic          busy, busyb;

  usrdemux_pkt #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .usrdemux_sel(sel), .s(s_if), .o1(o1_if), .o2(o2_if),
    .pkt_cnt1(cnt1), .pkt_cnt2(cnt2), .busy(busy)
  );

  usrdemux_pkt #(.WIDTH(W), .CNT_W(2)) dut_w2 (
    .clk(clk), .rst(rst), .usrdemux_sel(sel), .s(sb_if), .o1(o1b_if), .o2(o2b_if),
    .pkt_cnt1(cntb1), .pkt_cnt2(cntb2), .busy(busyb)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  logic [W:0] q1[$];
  logic [W:0] q2[$];
  int         pkts1 = 0;
  int         pkts2 = 0;
  bit         in_pkt = 1'b0;
  bit         route = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [W-1:0] d,
                           input logic l, input bit exp_v, input logic [W:0] head);
    check_val({tag, "_valid"}, {63'd0, v}, {63'd0, exp_v});
    if (exp_v && v) begin
      check_val({tag, "_data"}, d, head[W-1:0]);
      check_val({tag, "_last"}, {63'd0, l}, {63'd0, head[W]});
    end
  endtask

  task automatic model_reset();
    q1.delete();
    q2.delete();
    pkts1  = 0;
    pkts2  = 0;
    in_pkt = 1'b0;
    route  = 1'b0;
  endtask

  task automatic check_cycle();
    bit         tgt, exp_rdy, acc;
    logic [W:0] h1, h2, beat;
    h1 = (q1.size() != 0) ? q1[0] : '0;
    h2 = (q2.size() != 0) ? q2[0] : '0;
    check_out("o1", o1_if.valid, o1_if.data, o1_if.last, q1.size() != 0, h1);
    check_out("o2", o2_if.valid, o2_if.data, o2_if.last, q2.size() != 0, h2);
    check_out("w2_o1", o1b_if.valid, o1b_if.data, o1b_if.last, q1.size() != 0, h1);
    check_out("w2_o2", o2b_if.valid, o2b_if.data, o2b_if.last, q2.size() != 0, h2);
    check_val("pkt_cnt1", {48'd0, cnt1}, 64'(pkts1 % 65536));
    check_val("pkt_cnt2", {48'd0, cnt2}, 64'(pkts2 % 65536));
    check_val("w2_pkt_cnt1", {62'd0, cntb1}, 64'(pkts1 % 4));
    check_val("w2_pkt_cnt2", {62'd0, cntb2}, 64'(pkts2 % 4));
    check_val("busy", {63'd0, busy}, {63'd0, (in_pkt || q1.size() != 0 || q2.size() != 0)});
    check_val("w2_busy", {63'd0, busyb}, {63'd0, (in_pkt || q1.size() != 0 || q2.size() != 0)});

    // Target register is free if empty or draining this cycle.
    tgt = in_pkt ? route : sel;
    exp_rdy = tgt ? (q2.size() == 0 || o2_if.ready) : (q1.size() == 0 || o1_if.ready);
    check_val("s_ready", {63'd0, s_if.ready}, {63'd0, exp_rdy});
    check_val("w2_s_ready", {63'd0, sb_if.ready}, {63'd0, exp_rdy});

    // Advance the model across the coming edge.
    if (q1.size() != 0 && o1_if.ready) begin
      beat = q1.pop_front();
      if (beat[W]) pkts1++;
    end
    if (q2.size() != 0 && o2_if.ready) begin
      beat = q2.pop_front();
      if (beat[W]) pkts2++;
    end
    acc = s_if.valid && exp_rdy;
    if (acc) begin
      beat = {s_if.last, s_if.data};
      if (tgt) q2.push_back(beat);
      else     q1.push_back(beat);
      in_pkt = !s_if.last;
      route  = tgt;
    end
  endtask

  task automatic run_cycle(input bit do_rst, input bit drain);
    logic         v, l, r1, r2;
    logic [W-1:0] d;
    @(negedge clk);
    v  = drain ? 1'b0 : ($urandom_range(0, 3) != 0);
    d  = {$urandom, $urandom};
    l  = ($urandom_range(0, 2) == 0);
    r1 = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
    r2 = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
    rst = do_rst;
    sel = 1'($urandom_range(0, 1));
    s_if.valid  = v;  s_if.data  = d; s_if.last  = l;
    sb_if.valid = v;  sb_if.data = d; sb_if.last = l;
    o1_if.ready = r1; o1b_if.ready = r1;
    o2_if.ready = r2; o2b_if.ready = r2;
    #1;
    if (do_rst) model_reset();
    else        check_cycle();
  endtask

  initial begin
    s_if.valid = 1'b0;  s_if.data = '0;  s_if.last = 1'b0;
    sb_if.valid = 1'b0; sb_if.data = '0; sb_if.last = 1'b0;
    o1_if.ready = 1'b0; o2_if.ready = 1'b0;
    o1b_if.ready = 1'b0; o2b_if.ready = 1'b0;
    run_cycle(1'b1, 1'b0);
    run_cycle(1'b1, 1'b0);
    for (int i = 0; i < 2000; i++) begin
      run_cycle(i == 900 || i == 1400, 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      run_cycle(1'b0, 1'b1);
    end
    check_val("activity", {63'd0, (pkts1 > 20 && pkts2 > 20)}, 64'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/usrdemux_pkt.md
Name: usrdemux_pkt

Overview:
- Packet-aware 1-to-2 stream demultiplexer for the non-linear-op datapath; the dispatch-side counterpart of the 2:1 result mux.
- Accepts one valid/ready stream and steers each whole packet to output 1 or output 2, e.g. exp path vs. reciprocal path.
- The route is chosen from `usrdemux_sel` on the packet's first beat and locked until its last beat.
- Each output has a one-entry registered stage, giving 1-cycle latency and no combinational path from input data to output data.

Parameters:
- WIDTH, 64, data beat width in bits.
- CNT_W, 16, width of the per-output completed-packet counters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- usrdemux_sel  in  1  route request: 0 selects output 1, 1 selects output 2. Sampled only on the first beat of a packet.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid & s_ready.
- s_data  in  WIDTH  input beat data.
- s_last  in  1  marks the final beat of the packet.
- o1_valid  out  1  output 1 beat valid.
- o1_ready  in  1  output 1 downstream ready.
- o1_data  out  WIDTH  output 1 data.
- o1_last  out  1  output 1 last flag.
- o2_valid, o2_ready, o2_data, o2_last: same as o1_*, for output 2.
- pkt_cnt1  out  CNT_W  packets fully delivered on output 1 (counts o1 handshakes with o1_last=1). Wraps modulo 2^CNT_W.
- pkt_cnt2  out  CNT_W  same as pkt_cnt1, for output 2.
- busy  out  1  high when a packet is in progress or either output register holds data.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE.
  - o1_valid=o2_valid=0; o*_data=0; o*_last=0.
  - pkt_cnt1=pkt_cnt2=0; busy=0.
  - Reset mid-packet discards all held beats and the lock, with no partial-packet recovery.
- State machine:
  - States: IDLE, LOCK1, LOCK2.
  - Target: in IDLE, tgt=usrdemux_sel (combinational); in LOCK1, tgt=1; in LOCK2, tgt=2.
  - IDLE --accept, s_last=0--> LOCK(tgt).
  - IDLE --accept, s_last=1--> IDLE (single-beat packet).
  - LOCKn --accept, s_last=1--> IDLE.
  - LOCKn --otherwise--> LOCKn. Changes on usrdemux_sel are ignored while locked.
- Input handshake:
  - s_ready = ~o{tgt}_valid | o{tgt}_ready, i.e. the target register is empty or draining this cycle.
  - s_ready depends only on state, sel and the target output; it never depends on s_valid.
- Output register n, per edge:
  - Accepting a beat for n loads data and last and sets o{n}_valid=1.
  - Else, a handshake on n (o{n}_valid & o{n}_ready) clears o{n}_valid.
  - While o{n}_valid=1 and o{n}_ready=0, o{n}_data and o{n}_last are held stable.
- Latency and throughput:
  - A beat accepted at edge k appears on o{tgt} after edge k.
  - Full throughput is one beat per cycle when the target's o_ready is held high.
- Cross-packet overlap:
  - The non-target output may still hold the last beat of the previous packet. It drains independently.
  - A new packet to the other output can be accepted in the same cycle.
  - Both outputs may handshake in the same cycle.
- Counters:
  - pkt_cnt{n} increments by 1 on an o{n} handshake with o{n}_last=1.
  - The two counters are independent, so simultaneous increments both apply.
  - Wrap from 2^CNT_W-1 to 0 with no flag.
- busy = (state!=IDLE) | o1_valid | o2_valid.
- The unselected output never receives a beat of the locked packet.
- A packet's beats are never split across outputs and never reordered.

Decomposition:
- Package usrdemux_pkg holds:
  - the state enum (IDLE, LOCK1, LOCK2);
  - the constants SEL_O1=1'b0 and SEL_O2=1'b1.
- Sub-module usrdemux_oreg is the one-entry output register, instantiated twice. It contains:
  - the valid/data/last registers;
  - the "can_load" output equal to ~valid|ready;
  - the packet counter.
- The top level holds the FSM and target decode only.

Test Plan:
1. Reset, then a 4-beat packet with sel=0, data 0x10..0x13, last on 0x13, o1_ready=1:
   - o1 emits 0x10..0x13 on consecutive cycles, each one cycle after acceptance; o2_valid stays 0.
   - pkt_cnt1=1 and busy=0 after drain.
2. Same packet with sel=1, and sel toggled every cycle after the first beat:
   - all 4 beats go to o2; pkt_cnt2=1; o1_valid is never 1.
3. Backpressure: sel=0 packet, o1_ready=0 for 3 cycles after the first beat:
   - o1_data=0x10 is held stable and s_ready=0 while the register is full;
   - the stream resumes with no loss or duplication once o1_ready=1.
4. Overlap: a 1-beat packet 0xAA to o1 with o1_ready=0, then immediately a packet 0xBB,0xCC to o2 with o2_ready=1:
   - o2 delivers 0xBB,0xCC while o1 holds 0xAA;
   - release o1_ready together with o2's last handshake: pkt_cnt1 and pkt_cnt2 both increment on the same edge.
5. Reset asserted mid-packet after 2 of 4 beats with o1 holding data:
   - the next cycle shows o1_valid=0, state IDLE, counters 0, busy=0;
   - a new packet with sel=1 then routes to o2.
6. CNT_W=2, eight single-beat packets to o1:
   - pkt_cnt1 sequence is 1,2,3,0,1,2,3,0; pkt_cnt2 stays 0.
